// File: rtl/rank_seq.sv
// rank_seq: streams a k-combination (largest element first) and returns its colex rank sum C(c_i, i+1).
// Ports: start_valid/start_ready/start_k open a combination of k elements; elem_valid/elem_ready/elem
// carry the elements; out_valid/out_ready/rank/err return the result.
// Define RANK_CHECK_EN to flag out-of-range, non-descending or overflowing sequences on err.
module rank_seq #(
  parameter int NUM_WIDTH = 10,
  parameter int ROWS_NUM = 13,
  parameter int VALUE_WIDTH = 10,
  parameter int COL_WIDTH = 4,
  parameter int ROW_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [COL_WIDTH-1:0] start_k,
  input  logic                 elem_valid,
  output logic                 elem_ready,
  input  logic [ROW_WIDTH-1:0] elem,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_WIDTH-1:0] rank,
  output logic                 err
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state;
  logic [NUM_WIDTH-1:0] acc, next_acc;
  logic [COL_WIDTH-1:0] pos;
  logic [VALUE_WIDTH-1:0] tbl [2**ROW_WIDTH][2**COL_WIDTH];
  function automatic longint pascal(int n, int r);
    longint row [ROWS_NUM];
    for (int i = 0; i < ROWS_NUM; i++) row[i] = 0;
    row[0] = 1;
    for (int i = 1; i <= n; i++)
      for (int j = i; j > 0; j--) row[j] = row[j] + row[j-1];
    return row[r];
  endfunction
  // Table is padded to the full index space so out-of-range elem/pos read 0.
  for (genvar n = 0; n < 2**ROW_WIDTH; n++) begin : g_row
    for (genvar r = 0; r < 2**COL_WIDTH; r++) begin : g_col
      if (n < ROWS_NUM && r < ROWS_NUM) begin : g_val
        assign tbl[n][r] = VALUE_WIDTH'(pascal(n, r));
      end else begin : g_zero
        assign tbl[n][r] = '0;
      end
    end
  end
  assign next_acc = acc + NUM_WIDTH'(tbl[elem][pos]);
  assign start_ready = state == IDLE;
  assign elem_ready = state == ACCUM;
  assign out_valid = state == DONE;
  assign rank = acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      pos <= '0;
    end else begin
      unique case (state)
        IDLE: if (start_valid) begin
          pos <= start_k;
          acc <= '0;
          state <= start_k == '0 ? DONE : ACCUM;
        end
        ACCUM: if (elem_valid) begin
          acc <= next_acc;
          pos <= pos - 1'b1;
          state <= pos == COL_WIDTH'(1) ? DONE : ACCUM;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef RANK_CHECK_EN
  logic [ROW_WIDTH-1:0] prev;
  logic err_q, first;
  // A wrapped sum is smaller than the value it started from.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      first <= 1'b0;
      prev <= '0;
    end else if (state == IDLE && start_valid) begin
      err_q <= 32'(start_k) >= ROWS_NUM;
      first <= 1'b1;
    end else if (state == ACCUM && elem_valid) begin
      err_q <= err_q | (32'(elem) >= ROWS_NUM) | (!first && elem >= prev) | (next_acc < acc);
      first <= 1'b0;
      prev <= elem;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_rank_seq.sv
// tb_rank_seq: randomized and directed checks of rank_seq against a combinatorial reference model.
module tb_rank_seq;
  logic clk = 0, rst = 1;
  logic start_valid = 0, start_ready;
  logic [3:0] start_k = 0;
  logic elem_valid = 0, elem_ready;
  logic [3:0] elem = 0;
  logic out_valid, out_ready = 0;
  logic [9:0] rank;
  logic err;
  int n_cmp = 0, n_bad = 0;

  rank_seq dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready), .start_k(start_k),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .elem(elem),
    .out_valid(out_valid), .out_ready(out_ready), .rank(rank), .err(err)
  );

  always #5 clk = ~clk;

  function automatic longint cnk(int n, int r);
    longint c = 1;
    if (r < 0 || r > n) return 0;
    for (int i = 0; i < r; i++) c = c * (n - i) / (i + 1);
    return c;
  endfunction

  // Reference: rank = sum C(e_i, k-i) mod 1024; err flags bad inputs or a wrapping partial sum.
  function automatic void model(input int k, input int e[16], output int r, output int er);
    longint acc = 0, t;
    int bad = k >= 13;
    for (int i = 0; i < k; i++) begin
      t = e[i] < 13 ? cnk(e[i], k - i) % 1024 : 0;
      if (acc + t >= 1024) bad = 1;
      acc = (acc + t) % 1024;
      if (e[i] >= 13 || (i > 0 && e[i] >= e[i-1])) bad = 1;
    end
    r = int'(acc);
`ifdef RANK_CHECK_EN
    er = bad;
`else
    er = 0;
`endif
  endfunction

  task automatic run(input int k, input int e[16], input int bub, input int hold,
                     output int r, output int er, output bit to, output bit imm, output bit stable);
    int n, r0;
    to = 0; stable = 1; r = 0; er = 0;
    n = 0;
    while (!start_ready && n < 50) begin @(negedge clk); n++; end
    if (!start_ready) to = 1;
    start_valid = 1; start_k = k[3:0];
    @(negedge clk);
    start_valid = 0;
    for (int i = 0; i < k; i++) begin
      if (i == 1 && bub > 0) begin elem_valid = 0; repeat (bub) @(negedge clk); end
      elem_valid = 1; elem = e[i][3:0];
      n = 0;
      while (!elem_ready && n < 50) begin @(negedge clk); n++; end
      if (!elem_ready) to = 1;
      @(negedge clk);
    end
    elem_valid = 0;
    imm = out_valid; r0 = rank;
    repeat (hold) begin @(negedge clk); if (!out_valid || rank !== r0[9:0]) stable = 0; end
    out_ready = 1;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) to = 1;
    r = rank; er = err;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_cmp++; if ({out_valid, rank, err, start_ready, elem_ready} !== {1'b0, 10'd0, 1'b0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL reset_state got ov=%b rank=%0d err=%b sr=%b er=%b exp 0 0 0 1 0", out_valid, rank, err, start_ready, elem_ready);
    end
    start_valid = 1; start_k = 3; @(negedge clk); start_valid = 0;
    elem_valid = 1; elem = 5; @(negedge clk);
    elem = 3; @(negedge clk);
    elem_valid = 0; rst = 1; @(negedge clk); rst = 0;
    n_cmp++; if ({start_ready, out_valid, elem_ready} !== 3'b100) begin
      n_bad++; $display("FAIL mid_reset got sr=%b ov=%b er=%b exp 1 0 0", start_ready, out_valid, elem_ready);
    end
    repeat (5) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_no_result got ov=%b exp 0", out_valid); end
    end
  endtask

  task automatic check_one(input string nm, input int k, input int e[16], input int bub, input int hold, input bit chk_stable);
    int r, er, xr, xe; bit to, imm, st;
    model(k, e, xr, xe);
    run(k, e, bub, hold, r, er, to, imm, st);
    n_cmp++; if (to) begin n_bad++; $display("FAIL %s_timeout got timeout exp none", nm); end
    n_cmp++; if (r != xr) begin n_bad++; $display("FAIL %s_rank got %0d exp %0d", nm, r, xr); end
    n_cmp++; if (er != xe) begin n_bad++; $display("FAIL %s_err got %0d exp %0d", nm, er, xe); end
    n_cmp++; if (imm !== 1'b1) begin n_bad++; $display("FAIL %s_latency got ov=%b one cycle after last handshake exp 1", nm, imm); end
    if (chk_stable) begin
      n_cmp++; if (!st) begin n_bad++; $display("FAIL %s_stable got unstable output exp held", nm); end
    end
  endtask

  task automatic test_basic();
    int e[16] = '{default: 0};
    e[0] = 5; e[1] = 3; e[2] = 1;
    check_one("basic_531", 3, e, 0, 0, 0);
  endtask

  task automatic test_back_pressure();
    int e[16] = '{default: 0};
    e[0] = 12; e[1] = 11; e[2] = 10;
    check_one("bubble_12_11_10", 3, e, 2, 3, 1);
  endtask

  task automatic test_k0();
    int e[16] = '{default: 0};
    check_one("k0", 0, e, 0, 0, 0);
    e[0] = 1; e[1] = 0;
    check_one("k2_10", 2, e, 0, 0, 0);
  endtask

  task automatic test_errors();
    int e[16] = '{default: 0};
    e[0] = 3; e[1] = 3;
    check_one("dup_33", 2, e, 0, 0, 0);
    for (int i = 0; i < 6; i++) e[i] = 12 - i;
    check_one("wrap_12_7", 6, e, 0, 0, 0);
    for (int i = 0; i < 13; i++) e[i] = 12 - i;
    check_one("k13", 13, e, 0, 0, 0);
  endtask

  task automatic test_roundtrip();
    int e[16], rem, c, r, er; bit to, imm, st;
    for (int k = 0; k <= 3; k++)
      for (int rk = 0; rk < int'(cnk(13, k)); rk++) begin
        e = '{default: 0};
        rem = rk;
        for (int i = k; i >= 1; i--) begin
          c = i - 1;
          while (cnk(c + 1, i) <= rem) c++;
          e[k-i] = c;
          rem -= int'(cnk(c, i));
        end
        run(k, e, 0, 0, r, er, to, imm, st);
        n_cmp++; if (to || r != rk) begin
          n_bad++; $display("FAIL roundtrip_k%0d got %0d exp %0d timeout=%b", k, r, rk, to);
        end
      end
  endtask

  task automatic test_random();
    int e[16], k, need;
    for (int it = 0; it < 60; it++) begin
      e = '{default: 0};
      if (it % 2 == 0) begin
        k = int'($urandom_range(0, 12));
        need = k;
        for (int v = 12, j = 0; v >= 0; v--)
          if (int'($urandom_range(0, v)) < need) begin e[j] = v; j++; need--; end
      end else begin
        k = int'($urandom_range(0, 15));
        for (int i = 0; i < k; i++) e[i] = int'($urandom_range(0, 15));
      end
      check_one("random", k, e, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_k0();
    test_errors();
    test_roundtrip();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
